imm_gen_pipe: RTL

Registered, parametrised immediate generator for the decode stage. It extracts and sign- or zero-extends the immediate from a RISC-V instruction word for any `XLEN`. For branch, jump and AUIPC-type selects it also computes the PC-relative target and flags misaligned targets. A valid/ready handshake with a one-entry skid buffer lets the decode stage stall without a combinational `ready` path.

---
 rtl/imm_gen_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator for the decode stage.
// Extracts and extends the immediate selected by imm_sel, computes pc + imm
// and a misaligned-target flag for branches and jumps. A one-entry skid
// buffer behind the output register keeps in_ready a pure register output.
module imm_gen_pipe #(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   input  logic [2:0]      imm_sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] target,
   output logic            misalign
);

   localparam logic [2:0] SEL_S     = 3'd0;
   localparam logic [2:0] SEL_B     = 3'd1;
   localparam logic [2:0] SEL_U     = 3'd2;
   localparam logic [2:0] SEL_J     = 3'd3;
   localparam logic [2:0] SEL_I     = 3'd4;
   localparam logic [2:0] SEL_ISTAR = 3'd5;
   localparam logic [2:0] SEL_CSR   = 3'd6;

   // ------------------------------------------------------------------
   // Immediate decode. The low 32 bits are formed first; wider datapaths
   // replicate bit 31 for the signed formats and zero-fill otherwise.
   // ------------------------------------------------------------------
   logic [31:0]     imm32;
   logic            imm_signed;
   logic [XLEN-1:0] imm_next;
   logic [XLEN-1:0] target_next;
   logic            misalign_next;
   logic            is_branch_jump;

   // The opcode field never contributes to an immediate.
   logic            unused_opcode;
   assign unused_opcode = ^inst[6:0];

   // Format select: build the low word of the immediate.
   always_comb begin
      imm32      = 32'd0;
      imm_signed = 1'b0;
      case (imm_sel)
         SEL_I: begin
            imm32      = {{20{inst[31]}}, inst[31:20]};
            imm_signed = 1'b1;
         end
         SEL_ISTAR: begin
            // Shift amount is 6 bits wide only on a 64-bit datapath.
            if (XLEN == 64) begin
               imm32 = {26'd0, inst[25:20]};
            end else begin
               imm32 = {27'd0, inst[24:20]};
            end
         end
         SEL_S: begin
            imm32      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            imm_signed = 1'b1;
         end
         SEL_B: begin
            imm32      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
            imm_signed = 1'b1;
         end
         SEL_U: begin
            imm32      = {inst[31:12], 12'd0};
            imm_signed = 1'b1;
         end
         SEL_J: begin
            imm32      = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
            imm_signed = 1'b1;
         end
         SEL_CSR: begin
            imm32 = {27'd0, inst[19:15]};
         end
         default: begin
            imm32      = 32'd0;
            imm_signed = 1'b0;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < XLEN; gi++) begin : g_ext
         if (gi < 32) begin : g_low
            assign imm_next[gi] = imm32[gi];
         end else begin : g_high
            assign imm_next[gi] = imm_signed & imm32[31];
         end
      end
   endgenerate

   assign target_next    = pc + imm_next;
   assign is_branch_jump = (imm_sel == SEL_B) || (imm_sel == SEL_J);

   generate
      if (IALIGN == 16) begin : g_align16
         assign misalign_next = is_branch_jump & target_next[0];
      end else begin : g_align32
         assign misalign_next = is_branch_jump & target_next[1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Output register (OR) and skid register (SK).
   // ------------------------------------------------------------------
   logic            or_valid_reg, or_valid_next;
   logic            sk_valid_reg, sk_valid_next;
   logic [XLEN-1:0] or_imm_reg, or_target_reg;
   logic            or_misalign_reg;
   logic [XLEN-1:0] sk_imm_reg, sk_target_reg;
   logic            sk_misalign_reg;
   logic            or_load_new, or_load_sk, sk_load;
   logic            accept, drain;

   // in_ready comes straight from a flop, so out_ready never reaches it.
   assign in_ready = !sk_valid_reg;
   assign accept   = in_valid && in_ready;
   assign drain    = or_valid_reg && out_ready;

   // Handshake control: decide valid bits and which payload loads where.
   always_comb begin
      or_valid_next = or_valid_reg;
      sk_valid_next = sk_valid_reg;
      or_load_new   = 1'b0;
      or_load_sk    = 1'b0;
      sk_load       = 1'b0;
      if (flush) begin
         or_valid_next = 1'b0;
         sk_valid_next = 1'b0;
      end else if (drain && sk_valid_reg) begin
         or_valid_next = 1'b1;
         or_load_sk    = 1'b1;
         sk_valid_next = 1'b0;
      end else if (drain && accept) begin
         or_valid_next = 1'b1;
         or_load_new   = 1'b1;
      end else if (drain) begin
         or_valid_next = 1'b0;
      end else if (accept && !or_valid_reg) begin
         or_valid_next = 1'b1;
         or_load_new   = 1'b1;
      end else if (accept) begin
         sk_valid_next = 1'b1;
         sk_load       = 1'b1;
      end
   end

   // Valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_valid_reg <= 1'b0;
         sk_valid_reg <= 1'b0;
      end else begin
         or_valid_reg <= or_valid_next;
         sk_valid_reg <= sk_valid_next;
      end
   end

   // Output payload: loads only from the skid entry or a fresh beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_imm_reg      <= '0;
         or_target_reg   <= '0;
         or_misalign_reg <= 1'b0;
      end else if (or_load_sk) begin
         or_imm_reg      <= sk_imm_reg;
         or_target_reg   <= sk_target_reg;
         or_misalign_reg <= sk_misalign_reg;
      end else if (or_load_new) begin
         or_imm_reg      <= imm_next;
         or_target_reg   <= target_next;
         or_misalign_reg <= misalign_next;
      end
   end

   // Skid payload: captures a beat accepted while OR is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sk_imm_reg      <= '0;
         sk_target_reg   <= '0;
         sk_misalign_reg <= 1'b0;
      end else if (sk_load) begin
         sk_imm_reg      <= imm_next;
         sk_target_reg   <= target_next;
         sk_misalign_reg <= misalign_next;
      end
   end

   assign out_valid = or_valid_reg;
   assign imm       = or_imm_reg;
   assign target    = or_target_reg;
   assign misalign  = or_misalign_reg;

endmodule
